branch_resolver: RTL

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_if.sv | 52 +++++
 rtl/branch_resolver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolver_if.sv
// Decode-to-execute branch resolution bus.
// The pipeline side drives the instruction and advance enables; the resolver side returns
// the registered resolution, predictor-update and redirect controls.
interface branch_resolver_if #(
    parameter int ADDR_WIDTH = 32
);

    // Pipeline advance enables
    logic                  CACHE_READY;
    logic                  CACHE_READY_DATA;

    // Instruction at the stage input
    logic                  ID_VALID;
    logic [ADDR_WIDTH-1:0] ID_PC;
    logic [3:0]            ID_BR_TYPE;
    logic [ADDR_WIDTH-1:0] ID_RS1;
    logic [ADDR_WIDTH-1:0] ID_RS2;
    logic [ADDR_WIDTH-1:0] ID_IMM;
    logic                  ID_RS1_IS_RA;
    logic [ADDR_WIDTH-1:0] ID_PRD_ADDR;

    // Registered resolution results
    logic [ADDR_WIDTH-1:0] EX_PC;
    logic [ADDR_WIDTH-1:0] BRANCH_ADDR;
    logic [ADDR_WIDTH-1:0] RETURN_ADDR;
    logic                  BRANCH;
    logic                  BRANCH_TAKEN;
    logic                  PREDICTED;
    logic                  RETURN;
    logic                  FLUSH;
    logic [31:0]           BR_COUNT;
    logic [31:0]           MISS_COUNT;

    // Pipeline / decode side
    modport master (
        output CACHE_READY, CACHE_READY_DATA,
        output ID_VALID, ID_PC, ID_BR_TYPE, ID_RS1, ID_RS2, ID_IMM, ID_RS1_IS_RA, ID_PRD_ADDR,
        input  EX_PC, BRANCH_ADDR, RETURN_ADDR,
        input  BRANCH, BRANCH_TAKEN, PREDICTED, RETURN, FLUSH,
        input  BR_COUNT, MISS_COUNT
    );

    // Resolver side
    modport slave (
        input  CACHE_READY, CACHE_READY_DATA,
        input  ID_VALID, ID_PC, ID_BR_TYPE, ID_RS1, ID_RS2, ID_IMM, ID_RS1_IS_RA, ID_PRD_ADDR,
        output EX_PC, BRANCH_ADDR, RETURN_ADDR,
        output BRANCH, BRANCH_TAKEN, PREDICTED, RETURN, FLUSH,
        output BR_COUNT, MISS_COUNT
    );

endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: evaluates the branch condition and target of the instruction at the
// stage input, compares the real next PC against the fetch-stage prediction and produces
// registered predictor-update / redirect controls. After a mispredict, the next
// SHADOW_DEPTH accepted slots are wrong-path and are squashed without side effects.
module branch_resolver #(
    parameter int ADDR_WIDTH   = 32,
    parameter int SHADOW_DEPTH = 2
) (
    input logic              CLK,
    input logic              RSTN,
    branch_resolver_if.slave bus
);

    // Shadow counter wide enough to hold SHADOW_DEPTH; one bit minimum when unused.
    localparam int CNT_W = (SHADOW_DEPTH > 0) ? $clog2(SHADOW_DEPTH + 1) : 1;

    localparam logic [ADDR_WIDTH-1:0] LSB_CLEAR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [ADDR_WIDTH-1:0] INSN_SIZE = ADDR_WIDTH'(4);

    localparam logic [3:0] BrBeq  = 4'd1;
    localparam logic [3:0] BrBne  = 4'd2;
    localparam logic [3:0] BrBlt  = 4'd3;
    localparam logic [3:0] BrBge  = 4'd4;
    localparam logic [3:0] BrBltu = 4'd5;
    localparam logic [3:0] BrBgeu = 4'd6;
    localparam logic [3:0] BrJal  = 4'd7;
    localparam logic [3:0] BrJalr = 4'd8;

    typedef enum logic [0:0] {
        StResolve = 1'b0,
        StShadow  = 1'b1
    } state_e;

    state_e            state;
    logic [CNT_W-1:0]  shadow_cnt;

    logic                  advance;
    logic                  live;
    logic                  is_branch;
    logic                  is_jalr;
    logic                  cond_taken;
    logic                  taken;
    logic                  mispredict;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] actual_next;

    assign advance = bus.CACHE_READY & bus.CACHE_READY_DATA;
    // Only instructions seen outside the shadow window are architecturally real.
    assign live    = bus.ID_VALID && (state == StResolve);

    // Decode branch type and evaluate the branch condition.
    always_comb begin
        is_branch  = 1'b0;
        is_jalr    = 1'b0;
        cond_taken = 1'b0;
        case (bus.ID_BR_TYPE)
            BrBeq: begin
                is_branch  = 1'b1;
                cond_taken = (bus.ID_RS1 == bus.ID_RS2);
            end
            BrBne: begin
                is_branch  = 1'b1;
                cond_taken = (bus.ID_RS1 != bus.ID_RS2);
            end
            BrBlt: begin
                is_branch  = 1'b1;
                cond_taken = ($signed(bus.ID_RS1) < $signed(bus.ID_RS2));
            end
            BrBge: begin
                is_branch  = 1'b1;
                cond_taken = ($signed(bus.ID_RS1) >= $signed(bus.ID_RS2));
            end
            BrBltu: begin
                is_branch  = 1'b1;
                cond_taken = (bus.ID_RS1 < bus.ID_RS2);
            end
            BrBgeu: begin
                is_branch  = 1'b1;
                cond_taken = (bus.ID_RS1 >= bus.ID_RS2);
            end
            BrJal: begin
                is_branch  = 1'b1;
                cond_taken = 1'b1;
            end
            BrJalr: begin
                is_branch  = 1'b1;
                is_jalr    = 1'b1;
                cond_taken = 1'b1;
            end
            default: begin
                is_branch  = 1'b0;
                is_jalr    = 1'b0;
                cond_taken = 1'b0;
            end
        endcase
    end

    // Compute target, real next PC and the misprediction flag.
    always_comb begin
        target = '0;
        if (is_jalr) begin
            target = (bus.ID_RS1 + bus.ID_IMM) & LSB_CLEAR;
        end else begin
            target = bus.ID_PC + bus.ID_IMM;
        end
        pc_plus4    = bus.ID_PC + INSN_SIZE;
        taken       = is_branch & cond_taken;
        actual_next = taken ? target : pc_plus4;
        // Non-branches mispredict too when fetch did not fall through.
        mispredict  = (bus.ID_PRD_ADDR != actual_next);
    end

    // Shadow FSM and all registered outputs; everything holds while the pipeline stalls.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state            <= StResolve;
            shadow_cnt       <= '0;
            bus.EX_PC        <= '0;
            bus.BRANCH_ADDR  <= '0;
            bus.RETURN_ADDR  <= '0;
            bus.BRANCH       <= 1'b0;
            bus.BRANCH_TAKEN <= 1'b0;
            bus.PREDICTED    <= 1'b1;
            bus.RETURN       <= 1'b0;
            bus.FLUSH        <= 1'b0;
            bus.BR_COUNT     <= '0;
            bus.MISS_COUNT   <= '0;
        end else if (advance) begin
            if (live) begin
                bus.EX_PC        <= bus.ID_PC;
                bus.BRANCH       <= is_branch;
                bus.BRANCH_TAKEN <= taken;
                bus.BRANCH_ADDR  <= is_branch ? target : '0;
                bus.PREDICTED    <= ~mispredict;
                bus.FLUSH        <= mispredict;
                bus.RETURN       <= is_jalr & bus.ID_RS1_IS_RA;
                if (is_jalr) begin
                    bus.RETURN_ADDR <= target;
                end
                if (is_branch) begin
                    bus.BR_COUNT <= bus.BR_COUNT + 32'd1;
                end
                if (mispredict) begin
                    bus.MISS_COUNT <= bus.MISS_COUNT + 32'd1;
                    if (SHADOW_DEPTH > 0) begin
                        state      <= StShadow;
                        shadow_cnt <= CNT_W'(SHADOW_DEPTH);
                    end
                end
            end else begin
                // Bubble or wrong-path slot: quiet outputs, EX_PC / BRANCH_ADDR keep last value.
                bus.BRANCH       <= 1'b0;
                bus.BRANCH_TAKEN <= 1'b0;
                bus.RETURN       <= 1'b0;
                bus.FLUSH        <= 1'b0;
                bus.PREDICTED    <= 1'b1;
                if (state == StShadow) begin
                    shadow_cnt <= shadow_cnt - CNT_W'(1);
                    if (shadow_cnt <= CNT_W'(1)) begin
                        state <= StResolve;
                    end
                end
            end
        end
    end

endmodule
